// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of a synchronous FIFO, with bounded bursts and stall release.
// Optional per-requester beat statistics are enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4,
    parameter int STALL_MAX = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*8-1:0]   wr_data_in,
    output logic [NUM_REQ-1:0]     gnt,
    input  logic                   fifo_full,
    output logic                   fifo_wr_en,
    output logic [7:0]             fifo_wr_data,
    output logic                   busy
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                   stats_clr,
    output logic [NUM_REQ*16-1:0]  beat_count
`endif
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int BEAT_W  = $clog2(MAX_BURST + 1);
    localparam int STALL_W = $clog2(STALL_MAX + 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_t;

    state_t              r_state;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [IDX_W-1:0]    r_last_owner;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic [STALL_W-1:0]  r_stall_cnt;
    logic                r_busy;

    logic                w_owner_req;
    logic                w_accept;
    logic                w_release;
    logic                w_pick_valid;
    logic [IDX_W-1:0]    w_pick_idx;
    logic [7:0]          w_wr_data;

    // Scan last+1, last+2, ... so the previous owner gets lowest priority.
    function automatic logic [IDX_W:0] arb_pick(input logic [NUM_REQ-1:0] f_req,
                                                input logic [IDX_W-1:0]   f_last);
        logic             found;
        logic [IDX_W-1:0] pick;
        int               idx;
        found = 1'b0;
        pick  = f_last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(f_last) + k) % NUM_REQ;
            if (!found && f_req[idx]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end else begin
                found = found;
            end
        end
        return {found, pick};
    endfunction

    assign w_owner_req = |(r_gnt & req);
    assign w_accept    = w_owner_req & ~fifo_full;
    assign w_release   = ~w_owner_req
                       | (w_accept  && (r_beat_cnt  == BEAT_W'(MAX_BURST - 1)))
                       | (fifo_full && (r_stall_cnt == STALL_W'(STALL_MAX - 1)));
    assign {w_pick_valid, w_pick_idx} = arb_pick(req, r_last_owner);

    // Write-data mux driven by the one-hot grant; zero when nobody owns the port.
    always_comb begin
        w_wr_data = 8'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_gnt[i]) begin
                w_wr_data = w_wr_data | wr_data_in[8*i +: 8];
            end else begin
                w_wr_data = w_wr_data;
            end
        end
    end

    assign gnt          = r_gnt;
    assign busy         = r_busy;
    assign fifo_wr_en   = w_accept;
    assign fifo_wr_data = w_wr_data;

    // Arbitration FSM: grant, burst/stall accounting and same-edge hand-over.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_gnt        <= '0;
            r_last_owner <= IDX_W'(NUM_REQ - 1);
            r_beat_cnt   <= '0;
            r_stall_cnt  <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_state      <= ST_OWN;
                        r_gnt        <= NUM_REQ'(1) << w_pick_idx;
                        r_last_owner <= w_pick_idx;
                        r_beat_cnt   <= '0;
                        r_stall_cnt  <= '0;
                        r_busy       <= 1'b1;
                    end else begin
                        r_gnt  <= '0;
                        r_busy <= 1'b0;
                    end
                end
                ST_OWN: begin
                    if (w_release && w_pick_valid) begin
                        r_gnt        <= NUM_REQ'(1) << w_pick_idx;
                        r_last_owner <= w_pick_idx;
                        r_beat_cnt   <= '0;
                        r_stall_cnt  <= '0;
                        r_busy       <= 1'b1;
                    end else if (w_release) begin
                        r_state     <= ST_IDLE;
                        r_gnt       <= '0;
                        r_beat_cnt  <= '0;
                        r_stall_cnt <= '0;
                        r_busy      <= 1'b0;
                    end else begin
                        if (w_accept && (r_beat_cnt != BEAT_W'(MAX_BURST))) begin
                            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                        end else begin
                            r_beat_cnt <= r_beat_cnt;
                        end
                        if (!fifo_full) begin
                            r_stall_cnt <= '0;
                        end else if (r_stall_cnt != STALL_W'(STALL_MAX)) begin
                            r_stall_cnt <= r_stall_cnt + STALL_W'(1);
                        end else begin
                            r_stall_cnt <= r_stall_cnt;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_gnt       <= '0;
                    r_beat_cnt  <= '0;
                    r_stall_cnt <= '0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] r_beat_count;

    // Saturating per-requester accepted-beat counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_beat_count <= '0;
        end else if (stats_clr) begin
            r_beat_count <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_accept && r_gnt[i] && (r_beat_count[i] != 16'hFFFF)) begin
                    r_beat_count[i] <= r_beat_count[i] + 16'd1;
                end else begin
                    r_beat_count[i] <= r_beat_count[i];
                end
            end
        end
    end

    assign beat_count = r_beat_count;
`endif

endmodule
